wishbone_slave_regfile: RTL
===========================

WISHBONE_SLAVE_REGFILE -- requirements
Module: wishbone_slave_regfile

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits; a multiple of 8, range 8..64.
REQ-002 SHALL have parameter AW, default 4, address width in bits.
REQ-003 SHALL have parameter NUM_REGS, default 16, number of implemented registers; range 1..2**AW.
REQ-004 SHALL have parameter WAIT_STATES, default 0, extra cycles inserted before ack; range 0..7.
REQ-005 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port adr  input  AW  word address.
REQ-008 SHALL have port dat_mosi  input  DW  write data.
REQ-009 SHALL have port dat_miso  output  DW  read data.
REQ-010 SHALL have port sel  input  DW/8  byte-lane enables; bit i covers bits 8i+7..8i.
REQ-011 SHALL have port we  input  1  1 = write, 0 = read.
REQ-012 SHALL have port cyc  input  1  bus cycle active.
REQ-013 SHALL have port stb  input  1  strobe; a request is cyc & stb.
REQ-014 SHALL have port ack  output  1  normal termination, one-cycle pulse.
REQ-015 SHALL have port err  output  1  error termination, one-cycle pulse.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-017 In IDLE, a rising edge with cyc & stb = 1 SHALL latch adr, we, sel and dat_mosi, load the wait counter with WAIT_STATES, and go to WAIT if WAIT_STATES > 0, otherwise to RESP.
REQ-018 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 1.
REQ-019 In RESP, exactly one of ack or err SHALL be high for exactly one cycle, and the next state SHALL be IDLE.
REQ-020 Request-to-response latency SHALL be 1 + WAIT_STATES cycles, measured from the sampling edge to the first cycle ack or err is high.
REQ-021 A new request SHALL be sampled no earlier than the IDLE cycle following RESP, which gives a minimum of one idle cycle between transfers.
REQ-022 A write SHALL update only the byte lanes with sel = 1, and only on the edge that leaves RESP.
REQ-023 During RESP for a read, dat_miso SHALL present the latched-address register; in every other cycle it SHALL be 0.
REQ-024 A read-after-write to the same address SHALL return the new data.
REQ-025 If cyc falls in WAIT, the FSM SHALL return to IDLE on the next edge without a response and without a write.
REQ-026 A request with sel = 0 SHALL complete with ack and leave storage unchanged.
REQ-027 For an address >= NUM_REGS, the behaviour SHALL be as set in Configuration.
REQ-028 ack and err SHALL never be high in the same cycle.

Reset
REQ-029 Asserting rst SHALL immediately force the state to IDLE, the counter to 0, ack = 0, err = 0, dat_miso = 0 and all registers to 0.
REQ-030 A reset during WAIT or RESP SHALL abort the transfer, with no write and no further response.
REQ-031 After rst is released, the first rising edge SHALL be able to sample a request.

Configuration
REQ-032 Macro WB_SLAVE_ERR_EN SHALL control the out-of-range response.
REQ-033 With WB_SLAVE_ERR_EN defined, an out-of-range access SHALL be terminated with err instead of ack, SHALL not write, and SHALL return dat_miso = 0.
REQ-034 Without WB_SLAVE_ERR_EN, an out-of-range access SHALL be terminated with ack; reads SHALL return 0, writes SHALL be ignored, and err SHALL be tied to 0.

Verification
REQ-035 Scenario 1 (defaults): write 0xDEADBEEF to adr 1 with sel = 0xF, then read adr 1 -> ack one cycle after each sampling edge, read returns 0xDEADBEEF.
REQ-036 Scenario 2: fill adr 1 with 0xDEADBEEF, write 0x12345678 with sel = 0x5, then read -> 0xDE34BE78.
REQ-037 Scenario 3 (WAIT_STATES = 3): read adr 2 -> ack in the 4th cycle after sampling; dat_miso = 0 in all other cycles.
REQ-038 Scenario 4 (NUM_REGS = 8): write 0xCAFEBABE to adr 9, then read adr 9 -> err pulse with the macro defined, or ack with read 0 without it; adr 1 still holds its prior value.
REQ-039 Scenario 5 (WAIT_STATES = 2): drop cyc in WAIT -> no ack or err, register unchanged; next request completes normally.
REQ-040 Scenario 6: assert rst during a write in WAIT -> no write, outputs 0; a read afterwards returns 0.

Source files
------------

// File: rtl/wishbone_slave_regfile.sv
// Wishbone classic slave register file with byte lanes and programmable wait states.
// Define WB_SLAVE_ERR_EN to terminate out-of-range accesses with err instead of ack.
module wishbone_slave_regfile #(
    parameter int DW          = 32,
    parameter int AW          = 4,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   adr,
    input  logic [DW-1:0]   dat_mosi,
    output logic [DW-1:0]   dat_miso,
    input  logic [DW/8-1:0] sel,
    input  logic            we,
    input  logic            cyc,
    input  logic            stb,
    output logic            ack,
    output logic            err
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    localparam logic [2:0]  WS = 3'(WAIT_STATES);
    localparam logic [AW:0] NR = (AW + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [2:0]      cnt_q;
    logic [2:0]      cnt_d;
    logic            load;

    logic [AW-1:0]   adr_q;
    logic            we_q;
    logic [NB-1:0]   sel_q;
    logic [DW-1:0]   dat_q;

    logic            req;
    logic            resp;
    logic            in_range;
    logic            wr_en;

    logic [DEPTH-1:0][DW-1:0] rd_vec;

    assign req      = cyc & stb;
    assign resp     = (state_q == RESP);
    assign in_range = ({1'b0, adr_q} < NR);
    assign wr_en    = resp & we_q & in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    load  = 1'b1;
                    cnt_d = WS;
                    if (WAIT_STATES > 0)
                        state_d = WAIT;
                    else
                        state_d = RESP;
                end
            end
            WAIT: begin
                // Master gave up: drop the transfer silently.
                if (!cyc) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1)
                        state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_q <= '0;
            we_q  <= 1'b0;
            sel_q <= '0;
            dat_q <= '0;
        end else if (load) begin
            adr_q <= adr;
            we_q  <= we;
            sel_q <= sel;
            dat_q <= dat_mosi;
        end
    end

    // Storage is committed on the edge that leaves RESP.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (i < NUM_REGS) begin : g_impl
            logic [DW-1:0] r;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r <= '0;
                end else if (wr_en && adr_q == AW'(i)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (sel_q[b])
                            r[8*b +: 8] <= dat_q[8*b +: 8];
                    end
                end
            end

            assign rd_vec[i] = r;
        end else begin : g_none
            assign rd_vec[i] = '0;
        end
    end

    assign dat_miso = (resp && !we_q && in_range) ? rd_vec[adr_q] : '0;

`ifdef WB_SLAVE_ERR_EN
    assign ack = resp & in_range;
    assign err = resp & ~in_range;
`else
    assign ack = resp;
    assign err = 1'b0;
`endif

endmodule
